seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
- Scan controller for the serial run-of-ones detector datapath.
- Accepts a parallel word over a valid/ready handshake and feeds it one bit per clock, MSB first, through an internal Mealy run detector.
- Counts overlapping runs of RUN_LEN consecutive 1s, records the position of the first hit, and returns a result record over a second valid/ready handshake.
- Sits between a word-oriented producer and a status consumer, replacing free-running serial detection with sequenced, per-word scans.

Parameters:
- WIDTH, 8, bits per input word; must be >= 1.
- CNT_W, 4, width of the hit-count and index outputs; must satisfy WIDTH <= 2**CNT_W - 1.
- RUN_LEN, 3, consecutive 1s needed for a hit; must satisfy 1 <= RUN_LEN <= WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  controller can accept a word (IDLE only).
- in_data  in  WIDTH  word to scan; bit WIDTH-1 is scanned first (index 0).
- in_keep_hist  in  1  sampled with in_data. 1 = carry run history from the previous word; 0 = clear it.
- out_valid  out  1  result record valid.
- out_ready  in  1  consumer accepts the result.
- out_hits  out  CNT_W  number of hits in the word.
- out_first  out  CNT_W  scan index of the first hit; 0 when there are no hits.
- out_any  out  1  at least one hit.
- det_bit  out  1  bit being scanned this cycle.
- det_hit  out  1  Mealy hit flag for det_bit this cycle.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - Run counter, bit index, shift register, out_hits, out_first, out_any all = 0.
  - out_valid = 0, det_bit = 0, det_hit = 0.
  - in_ready = 1 whenever state is IDLE, including immediately after reset.
- FSM has three states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, at edge T:
    - load shift register and bit index = 0;
    - clear the hit count, first-hit index and any-hit flag;
    - if in_keep_hist = 0, clear the run counter;
    - go to SHIFT.
- SHIFT, one bit per cycle:
  - det_bit = current MSB of the shift register.
  - Run counter counts consecutive 1s and saturates at RUN_LEN-1. The saturated state self-loops on a 1, so runs overlap.
  - det_hit = det_bit & (run counter == RUN_LEN-1), combinational (Mealy).
  - On a 1: run counter increments, saturating. On a 0: run counter clears.
  - On a hit: hit count increments. On the first hit, the current bit index is recorded in out_first and out_any is set.
  - Shift left and increment the bit index.
  - After the bit with index WIDTH-1, go to REPORT.
- REPORT:
  - out_valid = 1.
  - out_hits, out_first and out_any are held stable until out_ready is sampled high.
  - On that edge, go to IDLE; out_valid drops the next cycle.
  - in_ready = 0 and in_valid is ignored.
- Outside SHIFT: det_bit = 0 and det_hit = 0. The run counter holds its value through REPORT and IDLE.
- Timing:
  - Word accepted at edge T; bits are scanned in cycles T+1 .. T+WIDTH; out_valid is high from cycle T+WIDTH+1.
  - Minimum spacing between accepted words is WIDTH+2 cycles.
- Width rules:
  - The hit count cannot overflow, given the parameter constraint.
  - The maximum number of hits is WIDTH-RUN_LEN+1 (all-ones word, no carried history).
- RUN_LEN = 1: the run counter is fixed at 0 and every 1 bit is a hit.
- Reset mid-scan or mid-report: the word is discarded, no out_valid is produced, and the controller returns to IDLE.
- in_data and in_keep_hist only need to be stable in the acceptance cycle.

Test Plan:
1. Default parameters; in_data = 8'b1111_0000, keep_hist = 0 -> det_hit sequence 0,0,1,1,0,0,0,0. out_hits = 2, out_first = 2, out_any = 1. out_valid rises 9 cycles after acceptance.
2. in_data = 8'b1101_1011, keep_hist = 0 -> no det_hit pulses; out_hits = 0, out_first = 0, out_any = 0.
3. Word 8'b0000_0011 (keep = 0), then word 8'b1000_0000:
   - with keep = 1 -> second result is hits = 1, first = 0;
   - repeat the pair with keep = 0 on the second word -> second result is hits = 0, any = 0.
4. in_data = 8'hFF, keep = 0 -> det_hit sequence 0,0,1,1,1,1,1,1. out_hits = 6, out_first = 2.
5. Hold out_ready = 0 for 5 cycles in REPORT while pulsing in_valid:
   - out_valid and the result fields stay stable; in_ready stays 0; no word is accepted;
   - after out_ready = 1, in_ready = 1 on the following cycle.
6. Assert rst_n = 0 during the 4th SHIFT cycle -> all outputs take their reset values immediately. After release: in_ready = 1, and no out_valid until a new word has been fully scanned.

Source files
------------

// File: rtl/seq_scan_ctrl_if.sv
// Handshake bundle for seq_scan_ctrl: a word-input channel (producer -> controller)
// and a result-record channel (controller -> consumer).
// The master modport is the environment side. The slave modport is the controller side.
`timescale 1ns/1ps

interface seq_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  // Word input channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_keep_hist;

  // Result record channel
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_hits;
  logic [CNT_W-1:0] out_first;
  logic             out_any;

  modport master (
    output in_valid,
    output in_data,
    output in_keep_hist,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_hits,
    input  out_first,
    input  out_any
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_keep_hist,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_hits,
    output out_first,
    output out_any
  );

endinterface

// File: rtl/seq_scan_ctrl.sv
// Per-word scan controller for the serial run-of-ones detector.
// A word is accepted in IDLE and shifted out MSB first, one bit per cycle, in SHIFT.
// A Mealy detector flags every bit that completes a run of RUN_LEN ones; runs may overlap.
// The hit count, the index of the first hit and an any-hit flag are then held in REPORT
// until the consumer takes them.
`timescale 1ns/1ps

module seq_scan_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 4,
  parameter int RUN_LEN = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_scan_ctrl_if.slave bus,
  output logic          det_bit,
  output logic          det_hit
);

  // Scan index of the last bit in a word.
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);
  // Saturation value of the run counter.
  // When the counter is here and the current bit is 1, a run of RUN_LEN ones is complete.
  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(RUN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_t;

  state_t           state_q, state_d;

  logic [WIDTH-1:0] shreg_q;   // remaining bits of the word, next bit at the MSB
  logic [CNT_W-1:0] idx_q;     // scan index of the bit currently at the MSB
  logic [CNT_W-1:0] run_q;     // consecutive ones seen, saturating at RUN_MAX
  logic [CNT_W-1:0] hits_q;
  logic [CNT_W-1:0] first_q;
  logic             any_q;

  logic             accept;    // word taken at this edge
  logic             scan;      // a bit is being scanned this cycle
  logic [CNT_W-1:0] run_nxt;

  // State register.
  // NOTE: sequential state is always written with non-blocking assignments.
  // Every register then samples pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode.
  // NOTE: every output of this block gets a default before the case statement.
  // Without the defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    scan          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scan = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        // in_valid is deliberately ignored here.
        // The next word waits until IDLE is reached.
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mealy detector.
  // The hit depends on the live bit as well as the stored run length.
  // So a run is flagged in the same cycle as the bit that completes it.
  always_comb begin
    det_bit = scan & shreg_q[WIDTH-1];
    det_hit = det_bit & (run_q == RUN_MAX);
    if (!det_bit) begin
      run_nxt = '0;
    end else if (run_q == RUN_MAX) begin
      // The counter stays saturated on further ones, so overlapping runs keep hitting.
      // With RUN_LEN = 1, RUN_MAX is 0 and the counter never moves.
      run_nxt = run_q;
    end else begin
      run_nxt = run_q + 1'b1;
    end
  end

  // Scan datapath.
  // This block loads a word on acceptance, shifts it, and accumulates the result fields.
  // Outside SHIFT the result fields are held, so the record stays stable through REPORT.
  // The run counter holds its value through REPORT and IDLE.
  // That held value is the history the next word can carry over with in_keep_hist = 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q   <= '0;
      run_q   <= '0;
      hits_q  <= '0;
      first_q <= '0;
      any_q   <= 1'b0;
    end else if (accept) begin
      shreg_q <= bus.in_data;
      idx_q   <= '0;
      hits_q  <= '0;
      first_q <= '0;
      any_q   <= 1'b0;
      if (!bus.in_keep_hist) begin
        run_q <= '0;
      end
    end else if (scan) begin
      shreg_q <= shreg_q << 1;
      idx_q   <= idx_q + 1'b1;
      run_q   <= run_nxt;
      if (det_hit) begin
        // The parameter constraint WIDTH <= 2**CNT_W - 1 guarantees this cannot wrap.
        hits_q <= hits_q + 1'b1;
        if (!any_q) begin
          first_q <= idx_q;
          any_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.out_hits  = hits_q;
  assign bus.out_first = first_q;
  assign bus.out_any   = any_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl with the default parameters.
// The test-plan words are run as directed steps with literal expectations.
// Random words are then scored against a reference model.
// The model tracks the length of the current run of ones as a plain unbounded integer.
// It flags a hit whenever that length reaches RUN_LEN.
`timescale 1ns/1ps

module tb_seq_scan_ctrl;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;
  localparam int RUN_LEN = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic det_bit;
  logic det_hit;

  always #5 clk = ~clk;

  seq_scan_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_scan_ctrl #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .RUN_LEN (RUN_LEN)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .det_bit (det_bit),
    .det_hit (det_hit)
  );

  int checks   = 0;
  int failures = 0;
  int run_model = 0;   // ones ending at the last scanned bit; cleared by reset

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-bit hits and result record for one word.
  // This also advances the carried run length.
  task automatic model_word(input logic [WIDTH-1:0] data, input bit keep,
                            output logic [WIDTH-1:0] hit_by_idx, output int hits,
                            output int first, output bit any);
    int r;
    r          = keep ? run_model : 0;
    hits       = 0;
    first      = 0;
    any        = 1'b0;
    hit_by_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r = data[WIDTH-1-i] ? r + 1 : 0;
      if (r >= RUN_LEN) begin
        hit_by_idx[i] = 1'b1;
        if (!any) first = i;
        any = 1'b1;
        hits++;
      end
    end
    run_model = r;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 50 && bus.in_ready !== 1'b1; n++) @(negedge clk);
    check("in_ready_wait", bus.in_ready, 1);
  endtask

  // Offer one word, check every scan cycle, check the report, then hold out_ready low
  // for 'stall' extra cycles while pulsing in_valid, and release.
  task automatic do_word(input logic [WIDTH-1:0] data, input bit keep, input int stall,
                         output int o_hits, output int o_first, output bit o_any);
    logic [WIDTH-1:0] exp_hit;
    int e_hits, e_first;
    bit e_any;
    wait_ready();
    model_word(data, keep, exp_hit, e_hits, e_first, e_any);
    bus.in_valid     = 1'b1;
    bus.in_data      = data;
    bus.in_keep_hist = keep;
    @(posedge clk);
    #1;
    bus.in_valid     = 1'b0;
    bus.in_data      = WIDTH'($urandom);
    bus.in_keep_hist = 1'($urandom);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check($sformatf("det_bit[%0d]", i), det_bit, data[WIDTH-1-i]);
      check($sformatf("det_hit[%0d]", i), det_hit, exp_hit[i]);
      check($sformatf("scan_out_valid[%0d]", i), bus.out_valid, 0);
      check($sformatf("scan_in_ready[%0d]", i), bus.in_ready, 0);
    end
    @(negedge clk);
    check("report_out_valid", bus.out_valid, 1);
    check("report_hits", bus.out_hits, e_hits);
    check("report_first", bus.out_first, e_first);
    check("report_any", bus.out_any, e_any);
    check("report_det_bit", det_bit, 0);
    o_hits  = int'(bus.out_hits);
    o_first = int'(bus.out_first);
    o_any   = bus.out_any;
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = (s % 2 == 0);
      bus.in_data  = WIDTH'($urandom);
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_hits", bus.out_hits, e_hits);
      check("stall_first", bus.out_first, e_first);
      check("stall_any", bus.out_any, e_any);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("release_out_valid", bus.out_valid, 0);
    check("release_in_ready", bus.in_ready, 1);
    check("release_det_bit", det_bit, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int h, f;
    bit a;
    logic [WIDTH-1:0] w;

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_keep_hist = 1'b0;
    bus.out_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_hits", bus.out_hits, 0);
    check("rst_first", bus.out_first, 0);
    check("rst_any", bus.out_any, 0);
    check("rst_det", {det_bit, det_hit}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);

    // Test plan 1: two overlapping hits starting at index 2.
    do_word(8'b1111_0000, 1'b0, 0, h, f, a);
    check("tp1_hits", h, 2);
    check("tp1_first", f, 2);
    check("tp1_any", a, 1);

    // Test plan 2: no run reaches three ones.
    do_word(8'b1101_1011, 1'b0, 0, h, f, a);
    check("tp2_hits", h, 0);
    check("tp2_first", f, 0);
    check("tp2_any", a, 0);

    // Test plan 3: history carried over a word boundary, then cleared.
    do_word(8'b0000_0011, 1'b0, 0, h, f, a);
    do_word(8'b1000_0000, 1'b1, 0, h, f, a);
    check("tp3_keep_hits", h, 1);
    check("tp3_keep_first", f, 0);
    do_word(8'b0000_0011, 1'b0, 0, h, f, a);
    do_word(8'b1000_0000, 1'b0, 0, h, f, a);
    check("tp3_clear_hits", h, 0);
    check("tp3_clear_any", a, 0);

    // Test plan 4: all ones gives the maximum hit count.
    do_word(8'hFF, 1'b0, 0, h, f, a);
    check("tp4_hits", h, WIDTH - RUN_LEN + 1);
    check("tp4_first", f, 2);

    // Test plan 5: back-pressure in REPORT while in_valid is pulsed.
    do_word(8'b0111_0111, 1'b0, 5, h, f, a);
    check("tp5_hits", h, 2);
    check("tp5_first", f, 3);

    // Test plan 6: reset during the 4th SHIFT cycle.
    wait_ready();
    bus.in_valid     = 1'b1;
    bus.in_data      = 8'hFF;
    bus.in_keep_hist = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("tp6_pre_det_bit", det_bit, 1);
    check("tp6_pre_det_hit", det_hit, 1);
    rst_n = 1'b0;
    #1;
    check("tp6_rst_in_ready", bus.in_ready, 1);
    check("tp6_rst_out_valid", bus.out_valid, 0);
    check("tp6_rst_det", {det_bit, det_hit}, 0);
    check("tp6_rst_fields", {bus.out_hits, bus.out_first, bus.out_any}, 0);
    run_model = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("tp6_no_out_valid[%0d]", i), bus.out_valid, 0);
    end
    check("tp6_idle_in_ready", bus.in_ready, 1);
    // Reset must also have cleared the run counter, so the carried history is empty.
    do_word(8'b1110_0000, 1'b1, 0, h, f, a);
    check("tp6_after_hits", h, 1);
    check("tp6_after_first", f, 2);

    // Randomized words scored against the model.
    for (int n = 0; n < 40; n++) begin
      w = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: w = w | 8'hF0;
        1: w = w | 8'h0F;
        2: w = w | 8'h3C;
        default: ;
      endcase
      do_word(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3), h, f, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
